// File: rtl/rr_arbiter_4_if.sv
// Request/grant bundle between four requesters and the round-robin arbiter.
// The arbiter takes the slave modport; the requester side takes master.
interface rr_arbiter_4_if;
    logic [3:0] req;
    logic       gnt_valid;
    logic [1:0] gnt_idx;
    logic [3:0] gnt_n;
    logic [7:0] hold_cnt;
    logic       state_dbg;

    modport master (
        output req,
        input  gnt_valid, gnt_idx, gnt_n, hold_cnt, state_dbg
    );

    modport slave (
        input  req,
        output gnt_valid, gnt_idx, gnt_n, hold_cnt, state_dbg
    );
endinterface

// File: rtl/rr_arbiter_4.sv
// Four-way round-robin arbiter with a bounded hold time and an active-low
// one-hot select. Every output comes from a flop.
module rr_arbiter_4 #(
    parameter int MAX_HOLD = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    rr_arbiter_4_if.slave  bus
);
    // Handshake: req is level-sensitive and sampled on every rising edge; a
    // grant stays valid for as long as gnt_valid is high, with no ready.

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_e;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_e     state_q, state_d;
    logic [1:0] owner_q, owner_d;
    logic [1:0] last_q, last_d;
    logic [7:0] hold_q, hold_d;
    logic [3:0] gnt_n_q, gnt_n_d;

    logic [3:0] pool;
    logic [1:0] base;
    logic       win_found;
    logic [1:0] win_idx;

    // Search starts just after base; base itself has lowest priority.
    function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] b);
        logic [2:0] res;
        logic [1:0] cand;
        res = 3'b000;
        for (int k = 4; k >= 1; k--) begin
            cand = b + 2'(k);
            if (r[cand]) res = {1'b1, cand};
        end
        return res;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= 2'd0;
            last_q  <= 2'd3;
            hold_q  <= 8'd0;
            gnt_n_q <= 4'b1111;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
            gnt_n_q <= gnt_n_d;
        end
    end

    // While granted, the owner is masked out and becomes the rotation base,
    // which covers both release and expiry.
    always_comb begin
        pool = bus.req;
        base = last_q;
        if (state_q == GRANT) begin
            pool = bus.req & ~(4'b0001 << owner_q);
            base = owner_q;
        end
        {win_found, win_idx} = pick(pool, base);
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = GRANT;
                    owner_d = win_idx;
                    hold_d  = 8'd0;
                end
            end
            GRANT: begin
                if (!bus.req[owner_q] || (hold_q == HOLD_LAST && pool != 4'b0000)) begin
                    last_d = owner_q;
                    hold_d = 8'd0;
                    if (win_found) begin
                        owner_d = win_idx;
                    end else begin
                        state_d = IDLE;
                        owner_d = 2'd0;
                    end
                end else if (hold_q != HOLD_LAST) begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                owner_d = 2'd0;
            end
        endcase
        gnt_n_d = (state_d == GRANT) ? ~(4'b0001 << owner_d) : 4'b1111;
    end

    always_comb begin
        bus.gnt_valid = (state_q == GRANT);
        bus.gnt_idx   = owner_q;
        bus.gnt_n     = gnt_n_q;
        bus.hold_cnt  = hold_q;
        bus.state_dbg = state_q;
    end
endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed scoreboard bench for rr_arbiter_4 with MAX_HOLD of 8, 4 and 1.
module tb_rr_arbiter_4;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    rr_arbiter_4_if if8 ();
    rr_arbiter_4_if if4 ();
    rr_arbiter_4_if if1 ();

    rr_arbiter_4 #(.MAX_HOLD(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
    rr_arbiter_4 #(.MAX_HOLD(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
    rr_arbiter_4 #(.MAX_HOLD(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

    // Entry layout: {dut_sel[1:0], valid, idx[1:0], gnt_n[3:0], hold[7:0]}
    logic [16:0] exp_q[$];
    logic [16:0] exp_e, act_e;
    int          n_checks = 0;
    int          n_fail   = 0;
    string       phase    = "init";

    function automatic logic [16:0] exp_word(input int sel, input logic v,
                                             input logic [1:0] idx, input logic [7:0] hold);
        logic [3:0] gn;
        gn = v ? ~(4'b0001 << idx) : 4'b1111;
        return {2'(sel), v, (v ? idx : 2'd0), gn, hold};
    endfunction

    function automatic logic [16:0] act_word(input int sel);
        case (sel)
            0:       return {2'd0, if8.gnt_valid, if8.gnt_idx, if8.gnt_n, if8.hold_cnt};
            1:       return {2'd1, if4.gnt_valid, if4.gnt_idx, if4.gnt_n, if4.hold_cnt};
            default: return {2'd2, if1.gnt_valid, if1.gnt_idx, if1.gnt_n, if1.hold_cnt};
        endcase
    endfunction

    task automatic set_req(input int sel, input logic [3:0] r);
        case (sel)
            0:       if8.req = r;
            1:       if4.req = r;
            default: if1.req = r;
        endcase
    endtask

    task automatic drive(input int sel, input logic [3:0] r, input logic v,
                         input logic [1:0] idx, input int hold);
        @(negedge clk);
        set_req(sel, r);
        exp_q.push_back(exp_word(sel, v, idx, 8'(hold)));
    endtask

    task automatic report(input string name, input logic [16:0] a, input logic [16:0] e);
        $display("FAIL %s dut%0d: got v=%b idx=%0d gnt_n=%b hold=%0d, want v=%b idx=%0d gnt_n=%b hold=%0d",
                 name, e[16:15], a[14], a[13:12], a[11:8], a[7:0],
                 e[14], e[13:12], e[11:8], e[7:0]);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_e = exp_q.pop_front();
                act_e = act_word(int'(exp_e[16:15]));
                n_checks++;
                if (act_e !== exp_e) begin
                    n_fail++;
                    report(phase, act_e, exp_e);
                end
            end
        end
    end

    initial begin
        rst_n  = 1'b0;
        if8.req = 4'b1111;
        if4.req = 4'b1111;
        if1.req = 4'b1111;

        phase = "reset_hold";
        for (int i = 0; i < 6; i++) drive(i % 3, 4'b1111, 1'b0, 2'd0, 0);
        @(negedge clk);
        if8.req = 4'b0000;
        if4.req = 4'b0000;
        if1.req = 4'b0000;
        rst_n   = 1'b1;

        phase = "single_hold8";
        drive(0, 4'b0100, 1'b1, 2'd2, 0);
        for (int i = 1; i <= 20; i++) drive(0, 4'b0100, 1'b1, 2'd2, (i < 7) ? i : 7);
        drive(0, 4'b0000, 1'b0, 2'd0, 0);

        phase = "rotate_hold4";
        for (int i = 0; i < 20; i++) drive(1, 4'b1111, 1'b1, 2'((i / 4) % 4), i % 4);
        drive(1, 4'b0000, 1'b0, 2'd0, 0);

        phase = "release_handover";
        drive(1, 4'b0010, 1'b1, 2'd1, 0);
        drive(1, 4'b1010, 1'b1, 2'd1, 1);
        drive(1, 4'b1010, 1'b1, 2'd1, 2);
        drive(1, 4'b1000, 1'b1, 2'd3, 0);
        drive(1, 4'b0000, 1'b0, 2'd0, 0);

        phase = "last_pointer";
        drive(0, 4'b0001, 1'b1, 2'd0, 0);
        drive(0, 4'b0001, 1'b1, 2'd0, 1);
        drive(0, 4'b0000, 1'b0, 2'd0, 0);
        drive(0, 4'b0011, 1'b1, 2'd1, 0);
        drive(0, 4'b0011, 1'b1, 2'd1, 1);
        drive(0, 4'b0000, 1'b0, 2'd0, 0);

        phase = "hold1_rotate";
        drive(2, 4'b0101, 1'b1, 2'd0, 0);
        drive(2, 4'b0101, 1'b1, 2'd2, 0);
        drive(2, 4'b0101, 1'b1, 2'd0, 0);
        drive(2, 4'b0100, 1'b1, 2'd2, 0);
        drive(2, 4'b0100, 1'b1, 2'd2, 0);
        drive(2, 4'b0000, 1'b0, 2'd0, 0);

        phase = "async_reset";
        drive(0, 4'b0100, 1'b1, 2'd2, 0);
        drive(0, 4'b0100, 1'b1, 2'd2, 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        act_e = act_word(0);
        exp_e = exp_word(0, 1'b0, 2'd0, 8'd0);
        n_checks++;
        if (act_e !== exp_e) begin
            n_fail++;
            report("async_reset_now", act_e, exp_e);
        end
        #1;
        rst_n = 1'b1;
        phase = "after_reset";
        drive(0, 4'b0101, 1'b1, 2'd0, 0);
        drive(0, 4'b0101, 1'b1, 2'd0, 1);
        drive(0, 4'b0000, 1'b0, 2'd0, 0);

        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
            #2;
        end
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, want 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
